// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 pipeline hazard logic: opcodes,
// sequencer state type and the "which source registers are read" helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  // rt is a genuine source only for R-type, beq and sw; for every other
  // opcode that field is a destination or immediate and must not match.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_compare.sv
// Combinational dependency check between the ID instruction and the
// EX/MEM destinations. Produces the stall length the ID instruction needs
// (0 = no hazard). The worst applicable hazard wins.
module hazard_compare
  import mips_pkg::*;
#(
  parameter int MAX_STALL = 2,
  parameter int CNT_W     = $clog2(MAX_STALL + 1)
) (
  input  logic [31:0]      instr,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_reg_write,
  input  logic [4:0]       id_ex_destination_reg,
  input  logic             ex_mem_mem_read,
  input  logic [4:0]       ex_mem_destination_reg,
  output logic [CNT_W-1:0] n_req
);

  // Stall lengths clipped to what the counter can represent.
  localparam logic [CNT_W-1:0] N_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] N_TWO = CNT_W'((MAX_STALL < 2) ? MAX_STALL : 2);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rt_used;
  logic       ex_hit;
  logic       mem_hit;
  logic       is_beq;

  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rt_used = uses_rt(opcode);
  assign is_beq  = (opcode == OP_BEQ);

  // Register $0 is hard-wired, so a zero destination never creates a hazard.
  assign ex_hit  = (id_ex_destination_reg != 5'd0) &&
                   ((id_ex_destination_reg == rs) ||
                    (rt_used && (id_ex_destination_reg == rt)));
  assign mem_hit = (ex_mem_destination_reg != 5'd0) &&
                   ((ex_mem_destination_reg == rs) ||
                    (rt_used && (ex_mem_destination_reg == rt)));

  // Low instruction bits carry rd/shamt/funct/immediate, never read here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[15:0];

  // Pick the longest stall among the hazards that apply.
  always_comb begin
    n_req = '0;
    if (is_beq) begin
      // beq compares in decode, so it needs operands one stage earlier
      // than ordinary ALU consumers do.
      if (id_ex_reg_write && !id_ex_mem_read && ex_hit) n_req = N_ONE;
      if (ex_mem_mem_read && mem_hit && (n_req < N_ONE)) n_req = N_ONE;
      if (id_ex_mem_read && ex_hit) n_req = N_TWO;
    end else begin
      // Non-branch consumers are covered by forwarding except load-use.
      if (id_ex_mem_read && ex_hit) n_req = N_ONE;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Decode-stage hazard controller: drives the active-low Data_Hazard stall
// and the IF/ID flush (Control_Hazard). Multi-cycle stalls are sequenced by
// a registered down-counter so they release after a fixed length regardless
// of what the pipeline inputs show meanwhile.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// cycle counters on outputs stall_cycles and flush_cycles.
module hazard_sequencer
  import mips_pkg::*;
#(
  parameter int MAX_STALL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_reg_write,
  input  logic [4:0]  id_ex_destination_reg,
  input  logic        ex_mem_mem_read,
  input  logic [4:0]  ex_mem_destination_reg,
  input  logic        branch_taken,
  input  logic        jump,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles,
`endif
  output logic        Data_Hazard,
  output logic        Control_Hazard
);

  localparam int CNT_W = $clog2(MAX_STALL + 1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_req;
  logic             dh_core;

  hazard_compare #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_compare (
    .instr                  (instr),
    .id_ex_mem_read         (id_ex_mem_read),
    .id_ex_reg_write        (id_ex_reg_write),
    .id_ex_destination_reg  (id_ex_destination_reg),
    .ex_mem_mem_read        (ex_mem_mem_read),
    .ex_mem_destination_reg (ex_mem_destination_reg),
    .n_req                  (n_req)
  );

  // State and stall counter registers; reset aborts any stall in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and raw stall output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dh_core = 1'b1;
    case (state_q)
      RUN: begin
        // First stall cycle is flagged combinationally with zero latency.
        if (n_req != '0) begin
          dh_core = 1'b0;
          cnt_d   = n_req - CNT_W'(1);
          if (n_req > CNT_W'(1)) state_d = STALL;
        end
      end
      STALL: begin
        // Inputs are ignored here; the counter alone decides the release.
        dh_core = 1'b0;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are pinned to idle values while reset is held; a stall masks
  // any flush because a branch cannot be resolved on stale operands.
  assign Data_Hazard    = reset | dh_core;
  assign Control_Hazard = ~reset & (branch_taken | jump) & dh_core;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters for stalled and flushed cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!Data_Hazard && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Control_Hazard && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule
